// File: rtl/ntt_loop_ctrl_if.sv
// Handshake and loop-index bundle between the NTT loop sequencer and its
// consumers (twiddle address generator, data-address path).
interface ntt_loop_ctrl_if;
    logic       start;
    logic       KD_mode;
    logic       inv;
    logic       hold;
    logic [3:0] Run_mode;
    logic       KD_mode_q;
    logic [2:0] p;
    logic [6:0] k;
    logic [6:0] j;
    logic       r2;
    logic       bf_valid;
    logic       stage_last;
    logic       busy;
    logic       done;

    modport master (
        output start, KD_mode, inv, hold,
        input  Run_mode, KD_mode_q, p, k, j, r2, bf_valid, stage_last, busy, done
    );

    modport slave (
        input  start, KD_mode, inv, hold,
        output Run_mode, KD_mode_q, p, k, j, r2, bf_valid, stage_last, busy, done
    );
endinterface

// File: rtl/ntt_loop_ctrl.sv
// Loop-index sequencer for the shared Kyber/Dilithium NTT core: one butterfly slot per cycle.
// Optional inter-stage bubbles are built only when NTT_LOOP_STAGE_GAP_EN is defined.
module ntt_loop_ctrl #(
    parameter int STAGE_GAP = 4
) (
    input logic            clk,
    input logic            rst,
    ntt_loop_ctrl_if.slave bus
);
    if (STAGE_GAP < 1 || STAGE_GAP > 15) begin : g_gap_range
        $error("ntt_loop_ctrl: STAGE_GAP must be in 1..15");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DONE} state_t;

    state_t     state_q, state_d;
    logic       kd_q, kd_d, inv_q, inv_d;
    logic [2:0] p_q, p_d;
    logic [6:0] k_q, k_d, j_q, j_d;
    logic [3:0] mode_q, mode_d;
    logic       r2_q, r2_d, vld_q, vld_d, last_q, last_d;
    logic       busy_q, busy_d, done_q, done_d;
`ifdef NTT_LOOP_STAGE_GAP_EN
    logic [3:0] gap_q, gap_d;
`endif

    // Kyber's radix-4 stages use nonstandard bounds; Dilithium is a pure power-of-two split.
    function automatic logic [6:0] j_max(input logic kd, input logic [2:0] p);
        logic [6:0] r;
        if (kd) r = 7'h7f >> (3'd7 - p);
        else begin
            case (p)
                3'd3:    r = 7'd127;
                3'd2:    r = 7'd31;
                3'd1:    r = 7'd7;
                default: r = 7'd1;
            endcase
        end
        return r;
    endfunction

    function automatic logic [6:0] k_max(input logic kd, input logic [2:0] p);
        logic [6:0] r;
        if (kd) r = 7'h7f >> p;
        else begin
            case (p)
                3'd3:    r = 7'd0;
                3'd2:    r = 7'd1;
                3'd1:    r = 7'd7;
                default: r = 7'd31;
            endcase
        end
        return r;
    endfunction

    function automatic logic [3:0] run_code(input logic kd, input logic inv, input logic fin);
        return 4'd3 + {2'b00, kd, 1'b0} + {1'b0, inv, 2'b00} + {3'b000, fin};
    endfunction

    function automatic logic [2:0] final_p(input logic kd, input logic inv);
        return inv ? (kd ? 3'd7 : 3'd3) : 3'd0;
    endfunction

    always_comb begin
        state_d = state_q;
        kd_d    = kd_q;
        inv_d   = inv_q;
        p_d     = p_q;
        k_d     = k_q;
        j_d     = j_q;
        vld_d   = 1'b0;
        last_d  = 1'b0;
        done_d  = 1'b0;
        busy_d  = 1'b1;
        mode_d  = run_code(kd_q, inv_q, 1'b0);
`ifdef NTT_LOOP_STAGE_GAP_EN
        gap_d   = gap_q;
`endif
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                mode_d = 4'd0;
                if (bus.start) begin
                    state_d = S_RUN;
                    kd_d    = bus.KD_mode;
                    inv_d   = bus.inv;
                    p_d     = bus.inv ? 3'd0 : (bus.KD_mode ? 3'd7 : 3'd3);
                    k_d     = 7'd0;
                    j_d     = 7'd0;
                    vld_d   = 1'b1;
                    busy_d  = 1'b1;
                    mode_d  = run_code(bus.KD_mode, bus.inv, 1'b0);
                end
            end
            S_RUN: begin
                if (last_q) begin
                    if (p_q == final_p(kd_q, inv_q)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        mode_d  = run_code(kd_q, inv_q, 1'b1);
                    end else begin
                        p_d = inv_q ? p_q + 3'd1 : p_q - 3'd1;
                        k_d = 7'd0;
                        j_d = 7'd0;
`ifdef NTT_LOOP_STAGE_GAP_EN
                        state_d = S_GAP;
                        gap_d   = 4'(STAGE_GAP - 1);
`else
                        vld_d   = 1'b1;
`endif
                    end
                end else begin
                    vld_d = 1'b1;
                    if (j_q == j_max(kd_q, p_q)) begin
                        j_d = 7'd0;
                        k_d = k_q + 7'd1;
                    end else begin
                        j_d = j_q + 7'd1;
                    end
                end
            end
            S_GAP: begin
`ifdef NTT_LOOP_STAGE_GAP_EN
                if (gap_q == 4'd0) begin
                    state_d = S_RUN;
                    vld_d   = 1'b1;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                mode_d  = 4'd0;
            end
            default: state_d = S_IDLE;
        endcase
        // stage_last travels with the butterfly it marks, so derive it from the next indices
        if (vld_d) last_d = (j_d == j_max(kd_d, p_d)) && (k_d == k_max(kd_d, p_d));
        r2_d = busy_d & (kd_d | (p_d == 3'd3));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            kd_q    <= 1'b0;
            inv_q   <= 1'b0;
            p_q     <= 3'd0;
            k_q     <= 7'd0;
            j_q     <= 7'd0;
            mode_q  <= 4'd0;
            r2_q    <= 1'b0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef NTT_LOOP_STAGE_GAP_EN
            gap_q   <= 4'd0;
`endif
        end else if (!bus.hold) begin
            state_q <= state_d;
            kd_q    <= kd_d;
            inv_q   <= inv_d;
            p_q     <= p_d;
            k_q     <= k_d;
            j_q     <= j_d;
            mode_q  <= mode_d;
            r2_q    <= r2_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef NTT_LOOP_STAGE_GAP_EN
            gap_q   <= gap_d;
`endif
        end
    end

    assign bus.Run_mode   = mode_q;
    assign bus.KD_mode_q  = kd_q;
    assign bus.p          = p_q;
    assign bus.k          = k_q;
    assign bus.j          = j_q;
    assign bus.r2         = r2_q;
    assign bus.bf_valid   = vld_q;
    assign bus.stage_last = last_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_ntt_loop_ctrl.sv
// Self-checking bench for ntt_loop_ctrl: spec-constant vector table, a trace model
// built from the stage/loop rules, and hand sequences for hold, reset and back-to-back runs.
module tb_ntt_loop_ctrl;
    localparam int STAGE_GAP = 4;
`ifdef NTT_LOOP_STAGE_GAP_EN
    localparam int GAP = STAGE_GAP;
`else
    localparam int GAP = 0;
`endif

    typedef struct packed {
        logic [3:0] mode;
        logic       kdq;
        logic [2:0] p;
        logic [6:0] k;
        logic [6:0] j;
        logic       r2;
        logic       vld;
        logic       last;
        logic       busy;
        logic       done;
    } obs_t;

    typedef struct {
        logic       kd;
        logic       inv;
        int         n_valid;
        int         n_gaps;
        int         first_p;
        int         last_p;
        logic [3:0] run_cd;
        logic [3:0] done_cd;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    obs_t exp_q[$];
    vec_t vecs[4];

    ntt_loop_ctrl_if bus();
    ntt_loop_ctrl #(.STAGE_GAP(STAGE_GAP)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t get_obs();
        obs_t o;
        o.mode = bus.Run_mode;
        o.kdq  = bus.KD_mode_q;
        o.p    = bus.p;
        o.k    = bus.k;
        o.j    = bus.j;
        o.r2   = bus.r2;
        o.vld  = bus.bf_valid;
        o.last = bus.stage_last;
        o.busy = bus.busy;
        o.done = bus.done;
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("mode=%b kdq=%0d p=%0d k=%0d j=%0d r2=%0d vld=%0d last=%0d busy=%0d done=%0d",
                         o.mode, o.kdq, o.p, o.k, o.j, o.r2, o.vld, o.last, o.busy, o.done);
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got {%s} want {%s}", name, fmt(got), fmt(want));
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Reference model: loop extents and codes taken straight from the scheme tables.
    function automatic int n_j(input logic kd, input int p);
        if (kd) return 1 << p;
        case (p)
            3:       return 128;
            2:       return 32;
            1:       return 8;
            default: return 2;
        endcase
    endfunction

    function automatic int n_k(input logic kd, input int p);
        if (kd) return 128 / n_j(kd, p);
        return (p == 3) ? 1 : 64 / n_j(kd, p);
    endfunction

    function automatic logic [3:0] code_of(input logic kd, input logic inv);
        case ({kd, inv})
            2'b00:   return 4'b0011;
            2'b10:   return 4'b0101;
            2'b01:   return 4'b0111;
            default: return 4'b1001;
        endcase
    endfunction

    function automatic obs_t mk(input logic [3:0] mode, input logic kdq, input int p, input int k,
                                input int j, input logic r2, input logic vld, input logic last,
                                input logic busy, input logic done);
        obs_t e;
        e.mode = mode; e.kdq = kdq; e.p = 3'(p); e.k = 7'(k); e.j = 7'(j);
        e.r2 = r2; e.vld = vld; e.last = last; e.busy = busy; e.done = done;
        return e;
    endfunction

    task automatic build_trace(input logic kd, input logic inv);
        int         ns;
        int         order[$];
        int         p, np, nk, nj;
        logic [3:0] rc;
        obs_t       e;
        exp_q.delete();
        ns = kd ? 8 : 4;
        rc = code_of(kd, inv);
        for (int s = 0; s < ns; s++) order.push_back(inv ? s : ns - 1 - s);
        for (int si = 0; si < ns; si++) begin
            p  = order[si];
            nk = n_k(kd, p);
            nj = n_j(kd, p);
            for (int kk = 0; kk < nk; kk++)
                for (int jj = 0; jj < nj; jj++)
                    exp_q.push_back(mk(rc, kd, p, kk, jj, kd || p == 3, 1'b1,
                                       kk == nk - 1 && jj == nj - 1, 1'b1, 1'b0));
            if (si < ns - 1) begin
                np = order[si + 1];
                for (int g = 0; g < GAP; g++)
                    exp_q.push_back(mk(rc, kd, np, 0, 0, kd || np == 3, 1'b0, 1'b0, 1'b1, 1'b0));
            end
        end
        e      = exp_q[exp_q.size() - 1];
        e.vld  = 1'b0;
        e.last = 1'b0;
        e.done = 1'b1;
        e.mode = 4'(rc + 4'd1);
        exp_q.push_back(e);
    endtask

    // Starts a transform from IDLE and follows the model cycle by cycle with random hold and
    // random noise on start/KD_mode/inv; held edges must leave every output untouched.
    task automatic run_model(input logic kd, input logic inv, input int hold_pct, input string tag);
        int   idx;
        int   budget;
        logic h;
        obs_t o;
        build_trace(kd, inv);
        idx    = 0;
        budget = 3 * exp_q.size() + 50;
        bus.start = 1'b1; bus.KD_mode = kd; bus.inv = inv; bus.hold = 1'b0;
        step();
        bus.start = 1'b0;
        for (int c = 0; c < budget && idx < exp_q.size(); c++) begin
            check($sformatf("%s_trace[%0d]", tag, idx), get_obs(), exp_q[idx]);
            h = (int'($urandom_range(99)) < hold_pct);
            bus.hold    = h;
            bus.start   = 1'($urandom_range(1));
            bus.KD_mode = 1'($urandom_range(1));
            bus.inv     = 1'($urandom_range(1));
            step();
            if (!h) idx++;
        end
        bus.hold = 1'b0;
        bus.start = 1'b0;
        check_int({tag, "_complete"}, idx, exp_q.size());
        o = get_obs();
        check_int({tag, "_idle_after_done"}, int'({o.mode, o.vld, o.busy, o.done}), 0);
    endtask

    initial begin
        obs_t o, frozen;
        int   nv, fp, lp, span, badmode, found;

        vecs[0] = '{kd: 1'b1, inv: 1'b0, n_valid: 1024, n_gaps: 7, first_p: 7, last_p: 0,
                    run_cd: 4'b0101, done_cd: 4'b0110};
        vecs[1] = '{kd: 1'b0, inv: 1'b0, n_valid: 320, n_gaps: 3, first_p: 3, last_p: 0,
                    run_cd: 4'b0011, done_cd: 4'b0100};
        vecs[2] = '{kd: 1'b1, inv: 1'b1, n_valid: 1024, n_gaps: 7, first_p: 0, last_p: 7,
                    run_cd: 4'b1001, done_cd: 4'b1010};
        vecs[3] = '{kd: 1'b0, inv: 1'b1, n_valid: 320, n_gaps: 3, first_p: 0, last_p: 3,
                    run_cd: 4'b0111, done_cd: 4'b1000};

        rst = 1'b0;
        bus.start = 1'b0; bus.KD_mode = 1'b0; bus.inv = 1'b0; bus.hold = 1'b0;
        step();
        step();
        check("reset_state", get_obs(), '0);
        rst = 1'b1;
        step();
        check("idle_after_reset", get_obs(), '0);

        // start with hold high in IDLE is not taken
        bus.start = 1'b1; bus.hold = 1'b1; bus.KD_mode = 1'b1;
        step();
        bus.start = 1'b0; bus.hold = 1'b0;
        o = get_obs();
        check_int("start_with_hold_ignored", int'({o.busy, o.vld, o.mode}), 0);

        // spec-constant table; each vector starts in the idle cycle right after the previous done
        for (int v = 0; v < 4; v++) begin
            nv = 0; fp = -1; lp = -1; span = -1; badmode = 0;
            bus.KD_mode = vecs[v].kd; bus.inv = vecs[v].inv; bus.start = 1'b1;
            step();
            bus.start = 1'b0;
            bus.KD_mode = ~vecs[v].kd;
            for (int c = 0; c < 3000; c++) begin
                o = get_obs();
                if (o.done) begin
                    span = c;
                    break;
                end
                if (o.vld) begin
                    nv++;
                    if (fp < 0) fp = int'(o.p);
                    lp = int'(o.p);
                end
                if (o.mode != vecs[v].run_cd || !o.busy || o.kdq != vecs[v].kd) badmode++;
                step();
            end
            check_int($sformatf("tbl%0d_valid_count", v), nv, vecs[v].n_valid);
            check_int($sformatf("tbl%0d_first_valid_to_done", v), span,
                      vecs[v].n_valid + GAP * vecs[v].n_gaps);
            check_int($sformatf("tbl%0d_first_p", v), fp, vecs[v].first_p);
            check_int($sformatf("tbl%0d_last_p", v), lp, vecs[v].last_p);
            check_int($sformatf("tbl%0d_run_mode_bad_cycles", v), badmode, 0);
            check_int($sformatf("tbl%0d_done_code", v), int'(o.mode), int'(vecs[v].done_cd));
            check_int($sformatf("tbl%0d_done_busy_vld", v), int'({o.busy, o.vld}), 2);
            step();
            o = get_obs();
            check_int($sformatf("tbl%0d_done_one_cycle", v), int'({o.busy, o.done}), 0);
        end

        // model-checked runs, consecutive so each start lands in the cycle after done
        run_model(1'b1, 1'b0, 0, "model_d_ntt");
        run_model(1'b0, 1'b0, 15, "model_k_ntt");
        run_model(1'b0, 1'b1, 15, "model_k_intt");
        run_model(1'b1, 1'b1, 10, "model_d_intt");
        run_model(1'($urandom_range(1)), 1'($urandom_range(1)), 20, "model_rand");

        // hold for 5 cycles at Dilithium p=4 k=3 j=9, with start pulses and input toggles
        nv = 0; found = 0;
        bus.KD_mode = 1'b1; bus.inv = 1'b0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            o = get_obs();
            if (o.vld && o.p == 3'd4 && o.k == 7'd3 && o.j == 7'd9) begin
                found = 1;
                break;
            end
            if (o.vld) nv++;
            step();
        end
        check_int("hold_target_reached", found, 1);
        frozen = o;
        for (int h = 0; h < 5; h++) begin
            bus.hold = 1'b1;
            bus.start = 1'(h & 1);
            bus.KD_mode = 1'(h & 1);
            bus.inv = ~bus.inv;
            step();
            check($sformatf("hold_frozen[%0d]", h), get_obs(), frozen);
        end
        bus.hold = 1'b0; bus.start = 1'b1; bus.KD_mode = 1'b0; bus.inv = 1'b1;
        step();
        bus.start = 1'b0;
        o = get_obs();
        check("hold_resume", o, mk(4'b0101, 1'b1, 4, 3, 10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
        nv++;
        span = -1;
        for (int c = 0; c < 2000; c++) begin
            o = get_obs();
            if (o.done) begin
                span = c;
                break;
            end
            if (o.vld) nv++;
            step();
        end
        check_int("hold_total_valid", nv, 1024);
        check_int("hold_done_code", int'(o.mode), 4'b0110);
        step();

        // asynchronous reset in the middle of Dilithium stage p=5
        found = 0;
        bus.KD_mode = 1'b1; bus.inv = 1'b0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            o = get_obs();
            if (o.vld && o.p == 3'd5 && o.k == 7'd1) begin
                found = 1;
                break;
            end
            step();
        end
        check_int("rst_target_reached", found, 1);
        #2 rst = 1'b0;
        #1 check("rst_async_clear", get_obs(), '0);
        step();
        step();
        check("rst_held_low", get_obs(), '0);
        rst = 1'b1;
        step();
        check("rst_released_no_done", get_obs(), '0);
        run_model(1'b0, 1'b0, 0, "post_rst_k_ntt");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
